// File: rtl/sram_sync_dualport_be.sv
// Dual-port synchronous SRAM with per-byte write enables, selectable read-during-write
// behaviour, optional output register and a sequential clear engine.
module sram_sync_dualport_be #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned OUT_REG        = 0,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clear_req,
    output logic                             busy,
    output logic                             collision,
    input  logic                             re_a,
    input  logic                             we_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [DATA_WIDTH-1:0]            data_a,
    output logic [DATA_WIDTH-1:0]            q_a,
    output logic                             valid_a,
    input  logic                             re_b,
    input  logic                             we_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            data_b,
    output logic [DATA_WIDTH-1:0]            q_b,
    output logic                             valid_b
);

    localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [ADDR_WIDTH-1:0]   clr_cnt_nxt;

    logic                    clearing_c;
    logic                    rd_a_c;
    logic                    rd_b_c;
    logic                    wr_a_c;
    logic                    wr_b_c;
    logic                    same_addr_c;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   old_a_c;
    logic [DATA_WIDTH-1:0]   old_b_c;
    logic [DATA_WIDTH-1:0]   wdata_a_c;
    logic [DATA_WIDTH-1:0]   wdata_b_c;
    logic [DATA_WIDTH-1:0]   rdata_a_c;
    logic [DATA_WIDTH-1:0]   rdata_b_c;

    logic [DATA_WIDTH-1:0]   q1_a;
    logic [DATA_WIDTH-1:0]   q1_b;
    logic                    v1_a;
    logic                    v1_b;

    // Replace the lanes of a word selected by the byte enables.
    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] word,
        input logic [DATA_WIDTH-1:0] data,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] r;
        r = word;
        for (int unsigned i = 0; i < NB; i++) begin
            if (be[i]) begin
                r[i*BYTE_WIDTH +: BYTE_WIDTH] = data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
        return r;
    endfunction

    // Clear engine state register; busy mirrors the CLEAR state as a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt <= '0;
            busy    <= (CLEAR_ON_RESET != 0);
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            busy    <= (state_nxt == ST_CLEAR);
        end
    end

    // Next-state logic: one address per cycle, leave after the last address.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_nxt = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Access qualification: user ports are locked out while clearing.
    always_comb begin
        clearing_c  = (state == ST_CLEAR);
        rd_a_c      = re_a & ~clearing_c;
        rd_b_c      = re_b & ~clearing_c;
        wr_a_c      = we_a & ~clearing_c;
        wr_b_c      = we_b & ~clearing_c;
        same_addr_c = (addr_a == addr_b);
    end

    // Write words and read data; port B lanes win where both ports hit the same word.
    always_comb begin
        old_a_c   = mem[addr_a];
        old_b_c   = mem[addr_b];
        wdata_a_c = merge_lanes(old_a_c, data_a, be_a);
        if (wr_a_c && same_addr_c) begin
            wdata_b_c = merge_lanes(wdata_a_c, data_b, be_b);
        end else begin
            wdata_b_c = merge_lanes(old_b_c, data_b, be_b);
        end
        rdata_a_c = old_a_c;
        rdata_b_c = old_b_c;
        if (RDW_MODE == 0) begin
            if (wr_a_c) begin
                rdata_a_c = merge_lanes(old_a_c, data_a, be_a);
            end
            if (wr_b_c) begin
                rdata_b_c = merge_lanes(old_b_c, data_b, be_b);
            end
        end
    end

    // Storage array; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (clearing_c) begin
            mem[clr_cnt] <= CLEAR_VALUE;
        end else begin
            if (wr_a_c && !(wr_b_c && same_addr_c)) begin
                mem[addr_a] <= wdata_a_c;
            end
            if (wr_b_c) begin
                mem[addr_b] <= wdata_b_c;
            end
        end
    end

    // First read stage and collision flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1_a      <= '0;
            q1_b      <= '0;
            v1_a      <= 1'b0;
            v1_b      <= 1'b0;
            collision <= 1'b0;
        end else begin
            v1_a      <= rd_a_c;
            v1_b      <= rd_b_c;
            collision <= wr_a_c & wr_b_c & same_addr_c;
            if (rd_a_c) begin
                q1_a <= rdata_a_c;
            end
            if (rd_b_c) begin
                q1_b <= rdata_b_c;
            end
        end
    end

    // Optional second stage moves data and valid together.
    if (OUT_REG != 0) begin : g_out_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q_a     <= '0;
                q_b     <= '0;
                valid_a <= 1'b0;
                valid_b <= 1'b0;
            end else begin
                valid_a <= v1_a;
                valid_b <= v1_b;
                if (v1_a) begin
                    q_a <= q1_a;
                end
                if (v1_b) begin
                    q_b <= q1_b;
                end
            end
        end
    end else begin : g_no_out_reg
        assign q_a     = q1_a;
        assign q_b     = q1_b;
        assign valid_a = v1_a;
        assign valid_b = v1_b;
    end

endmodule

// File: tb/tb_sram_sync_dualport_be.sv
// Bench for sram_sync_dualport_be: two instances (write-first/no out reg and read-first/out reg)
// share stimulus and are compared every cycle against a word-array reference model.
module tb_sram_sync_dualport_be;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 4;
    localparam int unsigned NB    = 4;
    localparam int unsigned DEPTH = 16;
    localparam logic [31:0] CV    = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic          re_a, we_a, re_b, we_b;
    logic [NB-1:0] be_a, be_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] data_a, data_b;

    logic          busy0, busy1, col0, col1;
    logic          va0, va1, vb0, vb1;
    logic [DW-1:0] qa0, qa1, qb0, qb1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mdl [DEPTH];
    bit          m_busy;
    int          m_cnt;
    bit          m_col;
    logic [31:0] e_qa [2];
    logic [31:0] e_qb [2];
    bit          e_va [2];
    bit          e_vb [2];
    logic [31:0] p_qa, p_qb;
    bit          p_va, p_vb;

    always #5 clk = ~clk;

    sram_sync_dualport_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut0 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy0), .collision(col0),
        .re_a(re_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(qa0), .valid_a(va0),
        .re_b(re_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(qb0), .valid_b(vb0)
    );

    sram_sync_dualport_be #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RDW_MODE(1), .OUT_REG(1),
        .CLEAR_ON_RESET(1), .CLEAR_VALUE(CV)
    ) dut1 (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy1), .collision(col1),
        .re_a(re_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .data_a(data_a),
        .q_a(qa1), .valid_a(va1),
        .re_b(re_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .data_b(data_b),
        .q_b(qb1), .valid_b(vb1)
    );

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b1;
        m_cnt  = 0;
        m_col  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            e_qa[i] = '0; e_qb[i] = '0; e_va[i] = 1'b0; e_vb[i] = 1'b0;
        end
        p_qa = '0; p_qb = '0; p_va = 1'b0; p_vb = 1'b0;
    endtask

    // One clock edge of the reference: array writes, then per-instance read results.
    task automatic model_edge();
        logic [31:0] old [DEPTH];
        bit          rd_a, rd_b;
        logic [31:0] new_a, new_b, old_a, old_b;
        if (rst) begin
            model_reset();
            return;
        end
        old  = mdl;
        rd_a = 1'b0;
        rd_b = 1'b0;
        new_a = '0; new_b = '0; old_a = '0; old_b = '0;
        if (m_busy) begin
            mdl[m_cnt] = CV;
            m_cnt++;
            if (m_cnt == DEPTH) m_busy = 1'b0;
            m_col = 1'b0;
        end else begin
            if (we_a) mdl[addr_a] = merge(mdl[addr_a], data_a, be_a);
            if (we_b) mdl[addr_b] = merge(mdl[addr_b], data_b, be_b);
            m_col = we_a && we_b && (addr_a == addr_b);
            rd_a  = re_a;
            rd_b  = re_b;
            old_a = old[addr_a];
            old_b = old[addr_b];
            new_a = we_a ? merge(old_a, data_a, be_a) : old_a;
            new_b = we_b ? merge(old_b, data_b, be_b) : old_b;
            if (clear_req) begin
                m_busy = 1'b1;
                m_cnt  = 0;
            end
        end
        e_va[0] = rd_a;
        e_vb[0] = rd_b;
        if (rd_a) e_qa[0] = new_a;
        if (rd_b) e_qb[0] = new_b;
        e_va[1] = p_va;
        e_vb[1] = p_vb;
        if (p_va) e_qa[1] = p_qa;
        if (p_vb) e_qb[1] = p_qb;
        p_va = rd_a;
        p_vb = rd_b;
        if (rd_a) p_qa = old_a;
        if (rd_b) p_qb = old_b;
    endtask

    task automatic check_outputs();
        chk("busy0", 32'(busy0), 32'(m_busy));
        chk("busy1", 32'(busy1), 32'(m_busy));
        chk("col0", 32'(col0), 32'(m_col));
        chk("col1", 32'(col1), 32'(m_col));
        chk("valid_a0", 32'(va0), 32'(e_va[0]));
        chk("valid_b0", 32'(vb0), 32'(e_vb[0]));
        chk("valid_a1", 32'(va1), 32'(e_va[1]));
        chk("valid_b1", 32'(vb1), 32'(e_vb[1]));
        chk("q_a0", qa0, e_qa[0]);
        chk("q_b0", qb0, e_qb[0]);
        chk("q_a1", qa1, e_qa[1]);
        chk("q_b1", qb1, e_qb[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle();
        clear_req = 1'b0;
        re_a = 1'b0; we_a = 1'b0; be_a = '0; addr_a = '0; data_a = '0;
        re_b = 1'b0; we_b = 1'b0; be_b = '0; addr_b = '0; data_b = '0;
    endtask

    // Counts cycles with busy high, bounded.
    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'd16);
    endtask

    typedef struct {
        logic [3:0]  be;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    initial begin
        vec_t        tbl [7];
        logic [31:0] got [4];
        int          nv;
        int          first_k, last_k;

        tbl[0] = '{4'hF, 4'd5,  32'hAABB_CCDD, 32'hAABB_CCDD};
        tbl[1] = '{4'h2, 4'd5,  32'h0000_1100, 32'hAABB_11DD};
        tbl[2] = '{4'h0, 4'd5,  32'hFFFF_FFFF, 32'hAABB_11DD};
        tbl[3] = '{4'h8, 4'd5,  32'h7700_0000, 32'h77BB_11DD};
        tbl[4] = '{4'h1, 4'd0,  32'h0000_00EE, 32'hDEAD_BEEE};
        tbl[5] = '{4'hF, 4'd15, 32'h1234_5678, 32'h1234_5678};
        tbl[6] = '{4'h6, 4'd15, 32'h00AB_CD00, 32'h12AB_CD78};

        idle();
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs();
        repeat (2) tick();
        rst = 1'b0;

        // Power-up clear: busy for exactly DEPTH cycles, then every word reads CLEAR_VALUE
        count_busy("clear_cycles");
        for (int i = 0; i < 16; i++) begin
            re_a = 1'b1; addr_a = 4'(i);
            re_b = 1'b1; addr_b = 4'(15 - i);
            tick();
            chk("clear_rd_a", qa0, CV);
            chk("clear_rd_b", qb0, CV);
        end
        idle();
        repeat (2) tick();

        // Byte-enable write table, read back on port A through both latencies
        for (int i = 0; i < 7; i++) begin
            we_a = 1'b1; be_a = tbl[i].be; addr_a = tbl[i].addr; data_a = tbl[i].data;
            tick();
            idle();
            re_a = 1'b1; addr_a = tbl[i].addr;
            tick();
            idle();
            chk("tbl_q0", qa0, tbl[i].exp);
            chk("tbl_v0", 32'(va0), 32'd1);
            tick();
            chk("tbl_q1", qa1, tbl[i].exp);
            chk("tbl_v1", 32'(va1), 32'd1);
        end

        // Same-port read-during-write: write-first vs read-first instance
        we_a = 1'b1; be_a = 4'hF; addr_a = 4'd3; data_a = 32'h1111_1111;
        tick();
        re_a = 1'b1; data_a = 32'h2222_2222;
        tick();
        idle();
        chk("rdw_first_q0", qa0, 32'h2222_2222);
        tick();
        chk("rdw_old_q1", qa1, 32'h1111_1111);

        // Cross-port: B reads the word A is writing and sees the old word
        we_a = 1'b1; be_a = 4'hF; addr_a = 4'd3; data_a = 32'h3333_3333;
        re_b = 1'b1; addr_b = 4'd3;
        tick();
        idle();
        chk("xport_q0", qb0, 32'h2222_2222);

        // Write-write collision at the same address
        we_a = 1'b1; be_a = 4'hF; addr_a = 4'd7; data_a = 32'h0101_0101;
        we_b = 1'b1; be_b = 4'h3; addr_b = 4'd7; data_b = 32'h0202_0202;
        tick();
        idle();
        chk("col_pulse0", 32'(col0), 32'd1);
        chk("col_pulse1", 32'(col1), 32'd1);
        re_a = 1'b1; addr_a = 4'd7;
        tick();
        idle();
        chk("col_once", 32'(col0), 32'd0);
        chk("col_word", qa0, 32'h0101_0202);
        tick();

        // Back-to-back port B reads through the output register
        for (int i = 0; i < 4; i++) begin
            we_a = 1'b1; be_a = 4'hF; addr_a = 4'(i); data_a = 32'h1000_0000 + 32'(i);
            tick();
        end
        idle();
        nv = 0; first_k = -1; last_k = -1;
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                re_b = 1'b1; addr_b = 4'(k);
            end else begin
                idle();
            end
            tick();
            if (vb1 === 1'b1) begin
                if (nv < 4) got[nv] = qb1;
                if (first_k < 0) first_k = k;
                last_k = k;
                nv++;
            end
        end
        chk("b2b_count", 32'(nv), 32'd4);
        chk("b2b_span", 32'(last_k - first_k), 32'd3);
        for (int i = 0; i < 4; i++) chk("b2b_data", got[i], 32'h1000_0000 + 32'(i));

        // Random two-port traffic against the model
        for (int k = 0; k < 400; k++) begin
            re_a = 1'($urandom_range(0, 1)); we_a = 1'($urandom_range(0, 1));
            be_a = 4'($urandom); addr_a = 4'($urandom); data_a = $urandom;
            re_b = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
            be_b = 4'($urandom); addr_b = 4'($urandom); data_b = $urandom;
            tick();
        end
        idle();
        repeat (2) tick();

        // Clear request, then reset at counter 8; writes while busy must not land
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        we_a = 1'b1; be_a = 4'hF; addr_a = 4'd9; data_a = 32'h0BAD_0BAD;
        for (int k = 0; k < 8; k++) begin
            if (k == 4) clear_req = 1'b1;
            tick();
            clear_req = 1'b0;
        end
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        tick();
        rst = 1'b0;
        count_busy("restart_cycles");
        idle();
        re_a = 1'b1; addr_a = 4'd9;
        tick();
        idle();
        chk("busy_write_dropped", qa0, CV);
        for (int i = 0; i < 16; i++) begin
            re_b = 1'b1; addr_b = 4'(i);
            tick();
        end
        idle();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
